ph_reg3_stream: RTL and testbench

//  Parasite-side block-transfer sequencer feeding the register-3 parasite-to-host 2-byte FIFO.

---
 rtl/ph_reg3_stream.sv | 150 +++++++++++++++
 tb/tb_ph_reg3_stream.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ph_reg3_stream.sv
// Parasite-side block-transfer sequencer: pulls bytes from a source stream and issues
// single-cycle write strobes into the R3 parasite-to-host FIFO, padding odd blocks in two-byte mode.
module ph_reg3_stream #(
    parameter int          LEN_W      = 16,
    parameter int          SETTLE_CYC = 2,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic             p_phi2,
    input  logic             p_rst,
    input  logic             p_start,
    input  logic [LEN_W-1:0] p_length,
    input  logic             p_one_byte,
    input  logic             p_abort,
    input  logic [7:0]       p_src_data,
    input  logic             p_src_valid,
    output logic             p_src_ready,
    input  logic             p_full,
    output logic [7:0]       p_data,
    output logic             p_selectData,
    output logic             p_rdnw,
    output logic             p_busy,
    output logic             p_done,
    output logic [LEN_W-1:0] p_remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SRC,
        S_WAIT_ROOM,
        S_WRITE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [2:0]     SETTLE_LAST = 3'(SETTLE_CYC - 1);
    localparam logic [LEN_W:0] CNT_ONE     = (LEN_W + 1)'(1);

    state_t           r_state;
    logic [LEN_W:0]   r_cnt;
    logic             r_pad_pending;
    logic [2:0]       r_settle;
    logic [7:0]       r_data;
    logic             r_sel;
    logic             r_rdnw;
    logic             r_busy;
    logic             r_done;

    logic             w_len_zero;
    logic             w_need_pad;
    logic [LEN_W:0]   w_len_ext;
    logic             w_pad_only;

    assign w_len_zero = (p_length == '0);
    assign w_need_pad = p_length[0] & ~p_one_byte;
    // One extra bit so a maximal odd length plus its pad still fits.
    assign w_len_ext  = {1'b0, p_length} + {{LEN_W{1'b0}}, w_need_pad};
    assign w_pad_only = r_pad_pending && (r_cnt == CNT_ONE);

    always_ff @(posedge p_phi2) begin
        if (p_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pad_pending <= 1'b0;
            r_settle      <= '0;
            r_data        <= 8'h00;
            r_sel         <= 1'b0;
            r_rdnw        <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_sel  <= 1'b0;
            r_rdnw <= 1'b1;
            if (p_abort && (r_state != S_IDLE)) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_cnt         <= '0;
                r_pad_pending <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (p_start) begin
                            if (w_len_zero) begin
                                r_done <= 1'b1;
                            end else begin
                                r_cnt         <= w_len_ext;
                                r_pad_pending <= w_need_pad;
                                r_busy        <= 1'b1;
                                r_state       <= S_WAIT_SRC;
                            end
                        end
                    end
                    S_WAIT_SRC: begin
                        if (w_pad_only) begin
                            r_data        <= PAD_BYTE;
                            r_pad_pending <= 1'b0;
                            r_state       <= S_WAIT_ROOM;
                        end else if (p_src_valid) begin
                            r_data  <= p_src_data;
                            r_state <= S_WAIT_ROOM;
                        end
                    end
                    S_WAIT_ROOM: begin
                        if (!p_full) begin
                            r_sel   <= 1'b1;
                            r_rdnw  <= 1'b0;
                            r_state <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                        r_settle <= '0;
                        r_state  <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        // Give the R3 full flag time to reflect the write just made.
                        if (r_settle == SETTLE_LAST) begin
                            if (r_cnt == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_WAIT_SRC;
                            end
                        end else begin
                            r_settle <= r_settle + 3'd1;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign p_src_ready  = (r_state == S_WAIT_SRC) && !w_pad_only;
    assign p_data       = r_data;
    assign p_selectData = r_sel;
    assign p_rdnw       = r_rdnw;
    assign p_busy       = r_busy;
    assign p_done       = r_done;
    assign p_remaining  = r_cnt[LEN_W] ? {LEN_W{1'b1}} : r_cnt[LEN_W-1:0];

endmodule

// File: tb/tb_ph_reg3_stream.sv
// Directed bench for ph_reg3_stream: scoreboard of expected strobe bytes, source and full-flag models.
module tb_ph_reg3_stream;

    localparam int LEN_W      = 16;
    localparam int SETTLE_CYC = 2;

    logic             p_phi2 = 1'b0;
    logic             p_rst = 1'b1;
    logic             p_start = 1'b0;
    logic [LEN_W-1:0] p_length = '0;
    logic             p_one_byte = 1'b0;
    logic             p_abort = 1'b0;
    logic [7:0]       p_src_data = 8'h00;
    logic             p_src_valid = 1'b0;
    logic             p_src_ready;
    logic             p_full = 1'b0;
    logic [7:0]       p_data;
    logic             p_selectData;
    logic             p_rdnw;
    logic             p_busy;
    logic             p_done;
    logic [LEN_W-1:0] p_remaining;

    ph_reg3_stream #(.LEN_W(LEN_W), .SETTLE_CYC(SETTLE_CYC), .PAD_BYTE(8'h00)) dut (
        .p_phi2(p_phi2), .p_rst(p_rst), .p_start(p_start), .p_length(p_length),
        .p_one_byte(p_one_byte), .p_abort(p_abort), .p_src_data(p_src_data),
        .p_src_valid(p_src_valid), .p_src_ready(p_src_ready), .p_full(p_full),
        .p_data(p_data), .p_selectData(p_selectData), .p_rdnw(p_rdnw),
        .p_busy(p_busy), .p_done(p_done), .p_remaining(p_remaining)
    );

    always #5 p_phi2 = ~p_phi2;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_strobes = 0;
    int         n_done = 0;
    int         n_src = 0;
    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int         strobe_cyc[$];
    bit         full_auto = 1'b0;
    bit         strobe_flag = 1'b0;
    bit         src_take = 1'b0;
    int         full_since = 0;
    bit         full_armed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge p_phi2);
        #1;
    endtask

    always @(posedge p_phi2) cyc <= cyc + 1;

    // Strobe monitor: pops the scoreboard on every write strobe.
    always @(negedge p_phi2) begin
        if (p_done) n_done++;
        if (p_selectData) begin
            n_strobes++;
            strobe_cyc.push_back(cyc);
            strobe_flag = 1'b1;
            chk("strobe_rdnw", 32'(p_rdnw), 32'd0);
            if (full_auto) chk("strobe_full_low", 32'(p_full), 32'd0);
            chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("strobe_data", 32'(p_data), 32'(exp_q.pop_front()));
            $display("strobe cyc=%0d data=%02h", cyc, p_data);
        end
    end

    // Source stream model.
    initial forever begin
        @(negedge p_phi2);
        src_take = p_src_valid && p_src_ready && !p_rst;
        @(posedge p_phi2);
        #1;
        if (src_take && src_q.size() != 0) begin
            void'(src_q.pop_front());
            n_src++;
        end
        p_src_valid = (src_q.size() != 0);
        p_src_data  = p_src_valid ? src_q[0] : 8'h00;
    end

    // Auto full-flag model: R3 reports full for a few cycles starting 4 cycles after each strobe.
    initial forever begin
        @(posedge p_phi2);
        #1;
        if (full_auto) begin
            if (strobe_flag) begin
                strobe_flag = 1'b0;
                full_since  = 0;
                full_armed  = 1'b1;
            end else if (full_armed) begin
                full_since++;
            end
            p_full = full_armed && (full_since >= 3) && (full_since <= 5);
            if (full_since > 5) full_armed = 1'b0;
        end else begin
            strobe_flag = 1'b0;
            full_armed  = 1'b0;
        end
    end

    task automatic start_block(input logic [LEN_W-1:0] len, input logic mode);
        p_length   = len;
        p_one_byte = mode;
        p_start    = 1'b1;
        tick();
        p_start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        int k;
        base = n_done;
        k = 0;
        while (n_done == base && k < budget) begin
            tick();
            k++;
        end
        chk($sformatf("%s_done_count", tag), 32'(n_done - base), 32'd1);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int k;
        k = 0;
        while (n_strobes < target && k < budget) begin
            tick();
            k++;
        end
        chk("wait_strobes_reached", 32'(n_strobes >= target), 32'd1);
    endtask

    initial begin
        int s0;
        int d0;
        int n0;
        int fall_cyc;
        int k;

        // Reset state
        p_rst = 1'b1;
        repeat (3) tick();
        chk("rst_sel", 32'(p_selectData), 32'd0);
        chk("rst_rdnw", 32'(p_rdnw), 32'd1);
        chk("rst_data", 32'(p_data), 32'd0);
        chk("rst_src_ready", 32'(p_src_ready), 32'd0);
        chk("rst_busy", 32'(p_busy), 32'd0);
        chk("rst_done", 32'(p_done), 32'd0);
        chk("rst_remaining", 32'(p_remaining), 32'd0);
        p_rst = 1'b0;
        tick();

        // One-byte mode, p_full rising after every strobe
        full_auto = 1'b1;
        src_q = '{8'hAA, 8'hBB, 8'hCC};
        exp_q = '{8'hAA, 8'hBB, 8'hCC};
        s0 = n_strobes;
        start_block(16'd3, 1'b1);
        chk("t1_remaining_start", 32'(p_remaining), 32'd3);
        chk("t1_busy", 32'(p_busy), 32'd1);
        wait_done("t1", 300);
        chk("t1_strobes", 32'(n_strobes - s0), 32'd3);
        chk("t1_remaining_end", 32'(p_remaining), 32'd0);
        chk("t1_busy_end", 32'(p_busy), 32'd0);
        chk("t1_done_width", 32'(p_done), 32'd0);
        full_auto = 1'b0;
        p_full = 1'b0;
        tick();

        // Two-byte mode, p_full held high after the second strobe
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        strobe_cyc.delete();
        s0 = n_strobes;
        start_block(16'd4, 1'b0);
        chk("t2_remaining_start", 32'(p_remaining), 32'd4);
        wait_strobes(s0 + 2, 100);
        tick();
        p_full = 1'b1;
        repeat (10) tick();
        p_full = 1'b0;
        fall_cyc = cyc;
        wait_done("t2", 300);
        chk("t2_strobes", 32'(n_strobes - s0), 32'd4);
        chk("t2_gap12", 32'((strobe_cyc.size() >= 2) ? strobe_cyc[1] - strobe_cyc[0] : 0),
            32'(SETTLE_CYC + 3));
        chk("t2_s3_after_full", 32'((strobe_cyc.size() >= 3) ? (strobe_cyc[2] > fall_cyc) : 0), 32'd1);

        // Two-byte mode odd length: pad byte, extra source byte left untouched
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h00};
        s0 = n_strobes;
        n0 = n_src;
        start_block(16'd3, 1'b0);
        chk("t3_remaining_start", 32'(p_remaining), 32'd4);
        wait_done("t3", 300);
        chk("t3_strobes", 32'(n_strobes - s0), 32'd4);
        chk("t3_src_handshakes", 32'(n_src - n0), 32'd3);
        src_q.delete();
        tick();

        // Zero-length start
        s0 = n_strobes;
        p_length = '0;
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        chk("t4_done", 32'(p_done), 32'd1);
        chk("t4_busy", 32'(p_busy), 32'd0);
        tick();
        chk("t4_done_width", 32'(p_done), 32'd0);
        chk("t4_busy2", 32'(p_busy), 32'd0);
        repeat (5) tick();
        chk("t4_strobes", 32'(n_strobes - s0), 32'd0);

        // Abort while stalled in WAIT_ROOM
        src_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        exp_q = '{8'h41};
        s0 = n_strobes;
        start_block(16'd4, 1'b1);
        wait_strobes(s0 + 1, 50);
        p_full = 1'b1;
        repeat (4) tick();
        chk("t5_busy_pre", 32'(p_busy), 32'd1);
        chk("t5_remaining_pre", 32'(p_remaining), 32'd3);
        chk("t5_ready_pre", 32'(p_src_ready), 32'd0);
        d0 = n_done;
        p_abort = 1'b1;
        tick();
        p_abort = 1'b0;
        chk("t5_busy_abort", 32'(p_busy), 32'd0);
        chk("t5_remaining_abort", 32'(p_remaining), 32'd0);
        chk("t5_done_abort", 32'(p_done), 32'd0);
        p_full = 1'b0;
        repeat (10) tick();
        chk("t5_strobes", 32'(n_strobes - s0), 32'd1);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        src_q.delete();
        src_q = '{8'h51, 8'h52};
        exp_q = '{8'h51, 8'h52};
        s0 = n_strobes;
        tick();
        start_block(16'd2, 1'b0);
        wait_done("t5b", 200);
        chk("t5b_strobes", 32'(n_strobes - s0), 32'd2);

        // Ignored restart while busy, then reset during a write strobe
        src_q = '{8'h5A, 8'hA5};
        exp_q = '{8'h5A, 8'hA5};
        s0 = n_strobes;
        start_block(16'd2, 1'b1);
        repeat (2) tick();
        p_length = 16'd9;
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        chk("t6_remaining_no_reload", 32'(p_remaining), 32'd1);
        chk("t6_busy", 32'(p_busy), 32'd1);
        k = 0;
        while (k < 40) begin
            @(negedge p_phi2);
            if (p_selectData) break;
            k++;
        end
        chk("t6_second_strobe_seen", 32'(k < 40), 32'd1);
        p_rst = 1'b1;
        @(posedge p_phi2);
        #1;
        chk("t6_rst_sel", 32'(p_selectData), 32'd0);
        chk("t6_rst_rdnw", 32'(p_rdnw), 32'd1);
        chk("t6_rst_busy", 32'(p_busy), 32'd0);
        chk("t6_rst_done", 32'(p_done), 32'd0);
        chk("t6_rst_remaining", 32'(p_remaining), 32'd0);
        chk("t6_rst_data", 32'(p_data), 32'd0);
        chk("t6_rst_ready", 32'(p_src_ready), 32'd0);
        p_rst = 1'b0;
        repeat (5) tick();
        chk("t6_strobes", 32'(n_strobes - s0), 32'd2);

        // Counter boundaries: maximal odd length with pad saturates, even length has no pad
        start_block(16'hFFFF, 1'b0);
        chk("t7_remaining_sat", 32'(p_remaining), 32'h0000FFFF);
        p_abort = 1'b1;
        tick();
        p_abort = 1'b0;
        chk("t7_remaining_abort", 32'(p_remaining), 32'd0);
        start_block(16'hFFFE, 1'b0);
        chk("t7_remaining_even", 32'(p_remaining), 32'h0000FFFE);
        p_abort = 1'b1;
        tick();
        p_abort = 1'b0;
        chk("t7_busy_abort", 32'(p_busy), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
